// File: rtl/xor_fault_monitor_pkg.sv
// Shared types and helpers for the XOR fault-injection monitor family.
// Imported by the monitor top and its interface.
package xor_fi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK
  } state_t;

  localparam int XOR_IN_W = 5;

  // Counters stick at their limit so a long run never reports a small wrapped count.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] limit);
    return (value >= limit) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/xor_fault_monitor_if.sv
// Host/target-facing signal bundle of the XOR fault monitor.
// The master side is the host plus target; the slave side is the monitor.
interface xor_fault_monitor_if #(
  parameter int CNT_W = 16
);

  logic                              start;
  logic                              stop;
  logic                              locate_mode;
  logic                              q_in;
  logic [xor_fi_pkg::XOR_IN_W-1:0]   a_out;
  logic                              osc_en;
  logic                              busy;
  logic                              fault_pulse;
  logic [xor_fi_pkg::XOR_IN_W-1:0]   fault_pattern;
  logic [CNT_W-1:0]                  fault_count;
  logic [CNT_W-1:0]                  vector_count;

  modport master (
    output start, stop, locate_mode, q_in,
    input  a_out, osc_en, busy, fault_pulse, fault_pattern, fault_count, vector_count
  );

  modport slave (
    input  start, stop, locate_mode, q_in,
    output a_out, osc_en, busy, fault_pulse, fault_pattern, fault_count, vector_count
  );

endinterface

// File: rtl/xor_fault_monitor_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
// Reusable by any target-monitor block that samples a foreign-domain signal.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/xor_fault_monitor.sv
// Sweeps all XOR input vectors into the target, checks its synchronized output
// against expected parity, and counts/latches mismatches for the host.
module xor_fault_monitor
  import xor_fi_pkg::*;
#(
  parameter int   SETTLE_CYCLES = 4,
  parameter int   CNT_W         = 16,
  parameter logic DISABLED_IN5  = 1'b1
) (
  input  logic               sysclk,
  input  logic               rst_n,
  xor_fault_monitor_if.slave bus
);

  localparam int               SC_W        = $clog2(SETTLE_CYCLES);
  localparam logic [SC_W-1:0]  SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t                state_q, state_nx;
  logic [XOR_IN_W-1:0]   a_q, a_nx;
  logic [XOR_IN_W-1:0]   pat_q, pat_nx;
  logic [SC_W-1:0]       settle_q, settle_nx;
  logic [CNT_W-1:0]      fc_q, fc_nx;
  logic [CNT_W-1:0]      vc_q, vc_nx;
  logic                  stop_pend_q, stop_pend_nx;
  logic                  busy_q, busy_nx;
  logic                  osc_q, osc_nx;
  logic                  pulse_q, pulse_nx;
  logic                  q_sync;
  logic                  expected_q;

  sync_2ff u_q_sync (
    .clk   (sysclk),
    .rst_n (rst_n),
    .d     (bus.q_in),
    .q     (q_sync)
  );

  // The sixth gate input sits at its disabled level while osc_en is low.
  assign expected_q = (^a_q) ^ DISABLED_IN5;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      pat_q       <= '0;
      settle_q    <= '0;
      fc_q        <= '0;
      vc_q        <= '0;
      stop_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      osc_q       <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      state_q     <= state_nx;
      a_q         <= a_nx;
      pat_q       <= pat_nx;
      settle_q    <= settle_nx;
      fc_q        <= fc_nx;
      vc_q        <= vc_nx;
      stop_pend_q <= stop_pend_nx;
      busy_q      <= busy_nx;
      osc_q       <= osc_nx;
      pulse_q     <= pulse_nx;
    end
  end

  always_comb begin
    state_nx     = state_q;
    a_nx         = a_q;
    pat_nx       = pat_q;
    settle_nx    = settle_q;
    fc_nx        = fc_q;
    vc_nx        = vc_q;
    stop_pend_nx = stop_pend_q;
    busy_nx      = busy_q;
    osc_nx       = 1'b0;
    pulse_nx     = 1'b0;

    unique case (state_q)
      IDLE: begin
        osc_nx = bus.locate_mode;
        if (bus.start) begin
          state_nx     = SETTLE;
          osc_nx       = 1'b0;
          a_nx         = '0;
          pat_nx       = '0;
          settle_nx    = '0;
          fc_nx        = '0;
          vc_nx        = '0;
          stop_pend_nx = 1'b0;
          busy_nx      = 1'b1;
        end
      end

      // A stop here only marks the run for ending; the vector still gets checked.
      SETTLE: begin
        if (bus.stop) begin
          stop_pend_nx = 1'b1;
        end
        if (settle_q == SETTLE_LAST) begin
          state_nx = CHECK;
        end else begin
          settle_nx = settle_q + 1'b1;
        end
      end

      CHECK: begin
        vc_nx = CNT_W'(sat_inc(32'(vc_q), 32'(CNT_MAX)));
        if (q_sync != expected_q) begin
          pulse_nx = 1'b1;
          pat_nx   = a_q;
          fc_nx    = CNT_W'(sat_inc(32'(fc_q), 32'(CNT_MAX)));
        end
        if (bus.stop || stop_pend_q) begin
          state_nx     = IDLE;
          busy_nx      = 1'b0;
          stop_pend_nx = 1'b0;
        end else begin
          state_nx  = SETTLE;
          a_nx      = a_q + 1'b1;
          settle_nx = '0;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign bus.a_out         = a_q;
  assign bus.osc_en        = osc_q;
  assign bus.busy          = busy_q;
  assign bus.fault_pulse   = pulse_q;
  assign bus.fault_pattern = pat_q;
  assign bus.fault_count   = fc_q;
  assign bus.vector_count  = vc_q;

endmodule
